// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver; rx_valid rises one clk after the tick sampling the stop bit.
// A frame is held until rx_ready and later frames are dropped with an overrun_err pulse; UART_RX_PARITY_EN adds even parity.
module uart_rx_core #(
    parameter int CLKRATE     = 50000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_in,
    input  logic                   rx_ready,
    output logic [WORD_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun_err,
    output logic                   rx_busy
);
    localparam int TICK_DIV = CLKRATE / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW       = $clog2(OVERSAMPLE);
    localparam int BW       = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t                 r_state;
    logic                   r_sync1, r_sync2;
    logic [TW-1:0]          r_tick_cnt;
    logic [OW-1:0]          r_os_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [WORD_LENGTH-1:0] r_shift;
    logic                   r_armed;
    logic                   w_rx, w_tick, w_start, w_half, w_full;

    assign w_rx    = r_sync2;
    assign w_tick  = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_start = (r_state == S_IDLE) && !w_rx && r_armed;
    assign w_half  = w_tick && (r_os_cnt == OW'(OVERSAMPLE / 2 - 1));
    assign w_full  = w_tick && (r_os_cnt == OW'(OVERSAMPLE - 1));
    assign rx_busy = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Restarting the divider on the start edge centres every later sample in its bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tick_cnt <= '0;
        else if (w_start || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic r_par, r_par_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par       <= 1'b0;
            r_par_err   <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            overrun_err <= 1'b0;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (w_tick)
                r_os_cnt <= r_os_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_rx)
                        r_armed <= 1'b1;
                    if (w_start) begin
                        r_state   <= S_START;
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        r_par     <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_os_cnt <= '0;
                        r_state  <= w_rx ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_full) begin
                        r_os_cnt <= '0;
                        r_shift  <= {w_rx, r_shift[WORD_LENGTH-1:1]};
`ifdef UART_RX_PARITY_EN
                        r_par    <= r_par ^ w_rx;
`endif
                        if (r_bit_cnt == BW'(WORD_LENGTH - 1)) begin
                            r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_full) begin
                        r_os_cnt  <= '0;
                        r_par_err <= (w_rx != r_par);
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_full) begin
                        r_os_cnt <= '0;
                        r_state  <= S_IDLE;
                        // A low stop bit disarms start detection until the line idles high.
                        r_armed  <= w_rx;
                        if (!rx_valid || rx_ready) begin
                            rx_data    <= r_shift;
                            frame_err  <= !w_rx;
                            rx_valid   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= r_par_err;
`endif
                        end else begin
                            overrun_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a 4-clock tick divider; parity steps follow UART_RX_PARITY_EN.
module tb_uart_rx_core;
    localparam int CLKRATE  = 7372800;
    localparam int BAUD     = 115200;
    localparam int WL       = 8;
    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int BIT_CLKS = OS * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // 3 clks of sync/edge detect, half a start bit, then data, parity and stop bits.
    localparam int LAT = 3 + (OS / 2) * DIV + (WL + 1 + PAR) * BIT_CLKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          rx_ready;
    logic [WL-1:0] rx_data;
    logic          rx_valid, parity_err, frame_err, overrun_err, rx_busy;

    uart_rx_core #(.CLKRATE(CLKRATE), .BAUD(BAUD), .WORD_LENGTH(WL), .OVERSAMPLE(OS)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       hs_cnt = 0, valid_cyc = 0, ov_cyc = 0, rise_cyc = 0;
    logic [7:0] last_data = '0;
    logic     last_pe = 1'b0, last_fe = 1'b0, prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            hs_cnt    <= hs_cnt + 1;
            last_data <= rx_data;
            last_pe   <= parity_err;
            last_fe   <= frame_err;
        end
        if (rx_valid) valid_cyc <= valid_cyc + 1;
        if (overrun_err) ov_cyc <= ov_cyc + 1;
        if (rx_valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    int vectors = 0, miscompares = 0;
    int fall_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 rx_in = b;
        repeat (BIT_CLKS - 1) @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        @(posedge clk);
        #1 rx_in = 1'b0;
        fall_cyc = cyc;
        repeat (BIT_CLKS - 1) @(posedge clk);
        for (int i = 0; i < WL; i++) send_bit(d[i]);
        if (PAR == 1) send_bit(pb);
        send_bit(sb);
    endtask

    int hs0, vc0, ov0;

    initial begin
        rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b1;
        idle(3);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_busy", rx_busy, 0);
        check("reset_perr", parity_err, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun_err, 0);
        rst = 1'b0;
        idle(BIT_CLKS);

        // Good frame 0xA5 (four ones -> even parity bit 0).
        hs0 = hs_cnt; vc0 = valid_cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(BIT_CLKS);
        check("a5_handshakes", hs_cnt - hs0, 1);
        check("a5_data", last_data, 8'hA5);
        check("a5_perr", last_pe, 0);
        check("a5_ferr", last_fe, 0);
        check("a5_valid_cycles", valid_cyc - vc0, 1);
        check("a5_latency", rise_cyc - fall_cyc, LAT);

        // 0x3C has four ones; a parity bit of 1 is a mismatch when parity is checked.
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(BIT_CLKS);
        check("3c_data", last_data, 8'h3C);
        check("3c_perr", last_pe, PAR);
        check("3c_ferr", last_fe, 0);

        // 0x55 with a low stop bit, then the line stays low.
        send_frame(8'h55, 1'b0, 1'b0);
        hs0 = hs_cnt;
        check("55_data", last_data, 8'h55);
        check("55_ferr", last_fe, 1);
        idle(2 * BIT_CLKS);
        check("55_busy_while_low", rx_busy, 0);
        check("55_no_restart", hs_cnt - hs0, 0);
        rx_in = 1'b1;
        idle(BIT_CLKS);

        // Start glitch: low for 4 ticks.
        hs0 = hs_cnt;
        rx_in = 1'b0;
        idle(8);
        check("glitch_busy_high", rx_busy, 1);
        idle(8);
        rx_in = 1'b1;
        idle(24);
        check("glitch_busy_low", rx_busy, 0);
        idle(BIT_CLKS);
        check("glitch_no_frame", hs_cnt - hs0, 0);
        check("glitch_no_valid", rx_valid, 0);

        // Back-to-back 0x11, 0x22 with the consumer stalled.
        rx_ready = 1'b0;
        ov0 = ov_cyc;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        idle(BIT_CLKS);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_data_held", rx_data, 8'h11);
        check("ovr_pulse_cycles", ov_cyc - ov0, 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        idle(2);
        check("ovr_drained_data", last_data, 8'h11);
        check("ovr_valid_cleared", rx_valid, 0);
        rx_ready = 1'b1;

        // Reset in the middle of data bit 4 of 0xFF, then 0x0F.
        hs0 = hs_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        idle(BIT_CLKS / 2);
        rst = 1'b1;
        idle(3);
        check("rst_busy", rx_busy, 0);
        check("rst_valid", rx_valid, 0);
        rst = 1'b0;
        rx_in = 1'b1;
        idle(2 * BIT_CLKS);
        check("rst_frame_abandoned", hs_cnt - hs0, 0);
        send_frame(8'h0F, 1'b0, 1'b1);
        idle(BIT_CLKS);
        check("0f_handshakes", hs_cnt - hs0, 1);
        check("0f_data", last_data, 8'h0F);
        check("0f_perr", last_pe, 0);
        check("0f_ferr", last_fe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
